// File: rtl/ft245_sync_burst_to_axis.sv
// FT245-style synchronous FIFO bus (1/2/4-byte lanes) to AXI-Stream bridge.
// RX and TX bursts are bounded by MAX_BURST; RX words land in a first-word-fall-through skid FIFO.
module ft245_sync_burst_to_axis #(
  parameter int unsigned BUS_WIDTH  = 1,
  parameter int unsigned MAX_BURST  = 64,
  parameter int unsigned SKID_DEPTH = 8,
  parameter int unsigned ARB_MODE   = 0
) (
  input  logic                   ft245_dclk,
  input  logic                   rstn,
  inout  wire  [BUS_WIDTH-1:0]   ft245_ben,
  inout  wire  [BUS_WIDTH*8-1:0] ft245_data,
  output logic                   ft245_rdn,
  output logic                   ft245_wrn,
  output logic                   ft245_siwun,
  input  logic                   ft245_txen,
  input  logic                   ft245_rxfn,
  output logic                   ft245_oen,
  output logic                   ft245_rstn,
  output logic                   ft245_wakeupn,
  output logic [BUS_WIDTH*8-1:0] m_axis_tdata,
  output logic [BUS_WIDTH-1:0]   m_axis_tkeep,
  output logic                   m_axis_tvalid,
  input  logic                   m_axis_tready,
  input  logic [BUS_WIDTH*8-1:0] s_axis_tdata,
  input  logic [BUS_WIDTH-1:0]   s_axis_tkeep,
  input  logic                   s_axis_tvalid,
  output logic                   s_axis_tready
);

  localparam int unsigned DW = BUS_WIDTH * 8;
  localparam int unsigned AW = $clog2(SKID_DEPTH);
  localparam logic [15:0] BURST_MAX   = 16'(MAX_BURST);
  localparam logic [AW:0] RX_ARM_MAX  = (AW+1)'(SKID_DEPTH - 4);
  localparam logic [AW:0] RX_STOP_MIN = (AW+1)'(SKID_DEPTH - 3);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RX_OE,
    S_RX_RD,
    S_RX_END,
    S_TX_WR
  } state_t;

  state_t            state_q, state_d;
  logic [15:0]       burst_cnt_q, burst_cnt_d;
  logic              rr_tx_q, rr_tx_d;
  logic              rstn_q;
  logic [AW:0]       wptr_q, rptr_q;
  logic [AW:0]       count, count_d;
  logic [BUS_WIDTH+DW-1:0] mem_q [SKID_DEPTH];

  logic push, pop, empty;
  logic rx_req, tx_req, rx_first, tx_beat, tx_drive;

  assign count = wptr_q - rptr_q;
  assign empty = (count == '0);
  assign push  = (state_q == S_RX_RD) & ~ft245_rxfn;
  assign pop   = ~empty & m_axis_tready;
  assign count_d = count + (AW+1)'(push) - (AW+1)'(pop);

  assign m_axis_tvalid = ~empty;
  assign {m_axis_tkeep, m_axis_tdata} = mem_q[rptr_q[AW-1:0]];

  assign tx_drive   = (state_q == S_TX_WR);
  assign ft245_data = tx_drive ? s_axis_tdata : 'z;
  assign ft245_ben  = tx_drive ? s_axis_tkeep : 'z;

  assign ft245_siwun   = 1'b1;
  assign ft245_wakeupn = 1'b1;
  assign ft245_rstn    = rstn_q;

  // rr_tx_q set means TX wins the next contended arbitration.
  assign rx_req   = ~ft245_rxfn & (count <= RX_ARM_MAX);
  assign tx_req   = ~ft245_txen & s_axis_tvalid;
  assign rx_first = (ARB_MODE == 0) || !tx_req || !rr_tx_q;

  always_comb begin
    state_d       = state_q;
    burst_cnt_d   = burst_cnt_q;
    rr_tx_d       = rr_tx_q;
    ft245_rdn     = 1'b1;
    ft245_wrn     = 1'b1;
    ft245_oen     = 1'b1;
    s_axis_tready = 1'b0;
    tx_beat       = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (rx_req && rx_first) begin
          state_d = S_RX_OE;
          rr_tx_d = 1'b1;
        end else if (tx_req) begin
          state_d = S_TX_WR;
          rr_tx_d = 1'b0;
        end
      end
      S_RX_OE: begin
        ft245_oen = 1'b0;
        state_d   = S_RX_RD;
      end
      S_RX_RD: begin
        ft245_oen = 1'b0;
        ft245_rdn = 1'b0;
        if (push && (burst_cnt_q < BURST_MAX)) burst_cnt_d = burst_cnt_q + 16'd1;
        // Stop on post-edge values so neither the burst cap nor the FIFO margin is overrun.
        if (ft245_rxfn || (burst_cnt_d >= BURST_MAX) || (count_d >= RX_STOP_MIN))
          state_d = S_RX_END;
      end
      S_RX_END: begin
        ft245_oen = 1'b0;
        state_d   = S_IDLE;
      end
      S_TX_WR: begin
        s_axis_tready = ~ft245_txen & (burst_cnt_q < BURST_MAX);
        tx_beat       = s_axis_tready & s_axis_tvalid;
        ft245_wrn     = ~tx_beat;
        if (tx_beat) burst_cnt_d = burst_cnt_q + 16'd1;
        if (ft245_txen || !s_axis_tvalid || (burst_cnt_d >= BURST_MAX))
          state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (state_d == S_IDLE) burst_cnt_d = '0;
  end

  always_ff @(posedge ft245_dclk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= S_IDLE;
      burst_cnt_q <= '0;
      rr_tx_q     <= 1'b0;
      rstn_q      <= 1'b0;
      wptr_q      <= '0;
      rptr_q      <= '0;
    end else begin
      state_q     <= state_d;
      burst_cnt_q <= burst_cnt_d;
      rr_tx_q     <= rr_tx_d;
      rstn_q      <= 1'b1;
      wptr_q      <= wptr_q + (AW+1)'(push);
      rptr_q      <= rptr_q + (AW+1)'(pop);
    end
  end

  always_ff @(posedge ft245_dclk) begin
    if (push) mem_q[wptr_q[AW-1:0]] <= {ft245_ben, ft245_data};
  end

endmodule

// File: tb/tb_ft245_sync_burst_to_axis.sv
// Directed-plus-random bench for ft245_sync_burst_to_axis (4-byte lanes, 16-word bursts, round-robin).
// A queue-based FT245 device and AXIS scoreboard supply all expected values.
module tb_ft245_sync_burst_to_axis;

  localparam int unsigned BW = 4;
  localparam int unsigned DW = 32;
  localparam int unsigned MB = 16;
  localparam int unsigned SD = 8;

  typedef logic [BW+DW-1:0] word_t;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  wire  [BW-1:0] ft_ben;
  wire  [DW-1:0] ft_data;
  logic rdn, wrn, siwun, oen, ft_rstn, wakeupn;
  logic txen, rxfn;
  logic [DW-1:0] m_tdata;
  logic [BW-1:0] m_tkeep;
  logic m_tvalid, m_tready;
  logic [DW-1:0] s_tdata;
  logic [BW-1:0] s_tkeep;
  logic s_tvalid, s_tready;
  word_t dev_word;

  assign ft_data = (!oen) ? dev_word[DW-1:0] : 'z;
  assign ft_ben  = (!oen) ? dev_word[BW+DW-1:DW] : 'z;

  ft245_sync_burst_to_axis #(
    .BUS_WIDTH(BW), .MAX_BURST(MB), .SKID_DEPTH(SD), .ARB_MODE(1)
  ) dut (
    .ft245_dclk(clk), .rstn(rstn),
    .ft245_ben(ft_ben), .ft245_data(ft_data),
    .ft245_rdn(rdn), .ft245_wrn(wrn), .ft245_siwun(siwun),
    .ft245_txen(txen), .ft245_rxfn(rxfn), .ft245_oen(oen),
    .ft245_rstn(ft_rstn), .ft245_wakeupn(wakeupn),
    .m_axis_tdata(m_tdata), .m_axis_tkeep(m_tkeep),
    .m_axis_tvalid(m_tvalid), .m_axis_tready(m_tready),
    .s_axis_tdata(s_tdata), .s_axis_tkeep(s_tkeep),
    .s_axis_tvalid(s_tvalid), .s_axis_tready(s_tready)
  );

  // Device / scoreboard model state
  word_t rx_src[$];
  word_t rx_out[$];
  word_t tx_src[$];
  word_t tx_bus[$];
  int    rx_idx, tx_idx, tx_beats, tx_stop_at;
  bit    rx_block, tx_on, txen_force;
  int    rdy_mode;
  int    cyc, occ, max_occ;
  logic  o_rdn, o_oen, o_wrn, o_stready;
  int    checks, errors;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Drive device/AXIS inputs at negedge, then record what will transfer on the next posedge.
  task automatic step();
    @(negedge clk);
    cyc++;
    rxfn     = rx_block || (rx_idx >= rx_src.size());
    dev_word = (rx_idx < rx_src.size()) ? rx_src[rx_idx] : '0;
    txen     = txen_force || ((tx_stop_at >= 0) && (tx_beats >= tx_stop_at));
    s_tvalid = tx_on && (tx_idx < tx_src.size());
    {s_tkeep, s_tdata} = s_tvalid ? tx_src[tx_idx] : '0;
    m_tready = (rdy_mode == 0) ? 1'b0 : (rdy_mode == 1) ? 1'b1 : 1'($urandom_range(0, 1));
    #1;
    o_rdn = rdn; o_oen = oen; o_wrn = wrn; o_stready = s_tready;
    if (!rdn && !rxfn) begin rx_idx++; occ++; end
    if (!wrn && !txen) begin tx_bus.push_back({ft_ben, ft_data}); tx_beats++; end
    if (s_tvalid && s_tready) tx_idx++;
    if (m_tvalid && m_tready) begin rx_out.push_back({m_tkeep, m_tdata}); occ--; end
    if (occ > max_occ) max_occ = occ;
  endtask

  task automatic clear_model();
    rx_src.delete(); rx_out.delete(); tx_src.delete(); tx_bus.delete();
    rx_idx = 0; tx_idx = 0; tx_beats = 0; tx_stop_at = -1;
    occ = 0; max_occ = 0;
  endtask

  task automatic drain_rx(input string tag, input int want, input int limit);
    int n;
    n = 0;
    while ((rx_out.size() < want) && (n < limit)) begin step(); n++; end
    chk({tag, "_done_in_time"}, 64'(rx_out.size() >= want), 64'(1));
  endtask

  task automatic chk_rx_order(input string tag, input int base);
    chk({tag, "_count"}, 64'(rx_out.size()), 64'(rx_src.size() - base));
    for (int i = 0; i < rx_out.size() && (base + i) < rx_src.size(); i++)
      chk($sformatf("%s_word%0d", tag, i), 64'(rx_out[i]), 64'(rx_src[base + i]));
  endtask

  task automatic chk_tx_order(input string tag);
    chk({tag, "_accept_vs_bus"}, 64'(tx_idx), 64'(tx_bus.size()));
    for (int i = 0; i < tx_bus.size() && i < tx_src.size(); i++)
      chk($sformatf("%s_beat%0d", tag, i), 64'(tx_bus[i]), 64'(tx_src[i]));
  endtask

  initial begin
    int t_oen, t_rdn, run, run_push, max_push, bursts, n, base;
    int last_kind, kind, alt_err, idle_gap, min_gap;
    bit rx_ended;
    word_t w;

    checks = 0; errors = 0; cyc = 0;
    rx_block = 0; tx_on = 0; txen_force = 1; rdy_mode = 0;
    rxfn = 1'b1; txen = 1'b1; s_tvalid = 1'b0; s_tdata = '0; s_tkeep = '0;
    m_tready = 1'b0; dev_word = '0;
    clear_model();

    // Reset values
    @(negedge clk); @(negedge clk);
    chk("rst_rdn", 64'(rdn), 64'(1));
    chk("rst_wrn", 64'(wrn), 64'(1));
    chk("rst_oen", 64'(oen), 64'(1));
    chk("rst_siwun", 64'(siwun), 64'(1));
    chk("rst_wakeupn", 64'(wakeupn), 64'(1));
    chk("rst_ft_rstn", 64'(ft_rstn), 64'(0));
    chk("rst_m_tvalid", 64'(m_tvalid), 64'(0));
    chk("rst_s_tready", 64'(s_tready), 64'(0));
    rstn = 1'b1;
    #1 chk("ft_rstn_before_edge", 64'(ft_rstn), 64'(0));
    @(posedge clk); #1;
    chk("ft_rstn_after_edge", 64'(ft_rstn), 64'(1));

    // 10-word RX burst, 0x41.. in the low lane, oen leads rdn by one cycle
    clear_model(); rdy_mode = 1;
    for (int i = 0; i < 10; i++) begin
      w = {4'($urandom_range(1, 15)), 24'($urandom), 8'(8'h41 + i)};
      rx_src.push_back(w);
    end
    t_oen = -1; t_rdn = -1; n = 0;
    while ((rx_out.size() < 10) && (n < 60)) begin
      step(); n++;
      if (t_oen < 0 && !o_oen) t_oen = cyc;
      if (t_rdn < 0 && !o_rdn) t_rdn = cyc;
    end
    chk("t1_done_in_time", 64'(rx_out.size()), 64'(10));
    chk("t1_oen_leads_rdn", 64'(t_rdn - t_oen), 64'(1));
    chk_rx_order("t1", 0);
    repeat (4) step();

    // 40 words held available: bursts capped at MAX_BURST, nothing lost or duplicated
    clear_model();
    for (int i = 0; i < 40; i++) rx_src.push_back({4'($urandom_range(1, 15)), 32'($urandom)});
    run = 0; run_push = 0; max_push = 0; bursts = 0; n = 0;
    while ((rx_out.size() < 40) && (n < 300)) begin
      base = rx_idx;
      step(); n++;
      if (!o_rdn) begin
        if (run == 0) bursts++;
        run++;
        run_push += rx_idx - base;
        if (run_push > max_push) max_push = run_push;
      end else begin
        run = 0; run_push = 0;
      end
    end
    chk("t2_done_in_time", 64'(rx_out.size()), 64'(40));
    chk("t2_max_burst_words", 64'(max_push), 64'(MB));
    chk("t2_burst_count", 64'(bursts), 64'(3));
    chk_rx_order("t2", 0);
    repeat (4) step();

    // Backpressure: RX stops with <=3 free entries, then drains in order
    clear_model(); rdy_mode = 0;
    for (int i = 0; i < 20; i++) rx_src.push_back({4'($urandom_range(1, 15)), 32'($urandom)});
    repeat (40) step();
    chk("t3_rdn_parked", 64'(o_rdn), 64'(1));
    chk("t3_fill_reached_margin", 64'(max_occ >= int'(SD) - 3), 64'(1));
    chk("t3_fill_within_depth", 64'(max_occ <= int'(SD)), 64'(1));
    chk("t3_tvalid_held", 64'(m_tvalid), 64'(1));
    rdy_mode = 2;
    drain_rx("t3", 20, 400);
    chk_rx_order("t3", 0);
    chk("t3_fill_bound_overall", 64'(max_occ <= int'(SD)), 64'(1));
    rdy_mode = 1;
    repeat (4) step();

    // Round-robin with both sides pending; turnaround gap between RX and TX
    clear_model(); rdy_mode = 1;
    for (int i = 0; i < 120; i++) begin
      rx_src.push_back({4'($urandom_range(1, 15)), 32'($urandom)});
      tx_src.push_back({4'($urandom_range(1, 15)), 32'(i)});
    end
    txen_force = 0; tx_on = 1;
    last_kind = 0; kind = 0; alt_err = 0; bursts = 0;
    rx_ended = 0; idle_gap = 0; min_gap = 1000;
    for (int c = 0; c < 160; c++) begin
      step();
      kind = (!o_rdn) ? 1 : (!o_wrn) ? 2 : 0;
      if (kind != 0 && kind != last_kind) begin
        bursts++;
        if (kind == 2 && rx_ended) begin
          if (idle_gap < min_gap) min_gap = idle_gap;
        end
      end
      if (kind == 1) begin rx_ended = 1; idle_gap = 0; end
      else if (kind == 2) rx_ended = 0;
      else if (o_oen && rx_ended) idle_gap++;
      if (kind != 0) begin
        if (kind == last_kind && bursts > 0 && run == 0) alt_err++;
        last_kind = kind;
        run = 1;
      end else run = 0;
    end
    chk("t4_bursts_seen", 64'(bursts >= 4), 64'(1));
    chk("t4_alternation_errors", 64'(alt_err), 64'(0));
    chk("t4_rx_to_tx_idle_gap", 64'(min_gap >= 1 && min_gap < 1000), 64'(1));
    tx_on = 0;
    drain_rx("t4", 120, 600);
    chk_rx_order("t4", 0);
    chk_tx_order("t4");
    txen_force = 1;
    repeat (4) step();

    // txen rises after 5 beats: exactly 5 transfer, tready drops, the rest are held
    clear_model(); txen_force = 0; tx_on = 1;
    for (int i = 0; i < 10; i++) tx_src.push_back({4'($urandom_range(1, 15)), 32'($urandom)});
    tx_stop_at = 5; n = 0;
    while ((tx_beats < 5) && (n < 50)) begin step(); n++; end
    chk("t5_five_in_time", 64'(tx_beats), 64'(5));
    step();
    chk("t5_tready_drops", 64'(o_stready), 64'(0));
    chk("t5_wrn_high", 64'(o_wrn), 64'(1));
    repeat (8) step();
    chk("t5_beats_frozen", 64'(tx_beats), 64'(5));
    chk("t5_accepted_frozen", 64'(tx_idx), 64'(5));
    chk("t5_tvalid_held", 64'(s_tvalid), 64'(1));
    chk("t5_next_word_held", 64'({s_tkeep, s_tdata}), 64'(tx_src[5]));
    tx_stop_at = -1; n = 0;
    while ((tx_beats < 10) && (n < 50)) begin step(); n++; end
    chk("t5_all_in_time", 64'(tx_beats), 64'(10));
    chk_tx_order("t5");
    tx_on = 0; txen_force = 1;
    repeat (4) step();

    // Mid-burst reset: immediate return to idle outputs, FIFO flushed, clean restart
    clear_model(); rdy_mode = 1;
    for (int i = 0; i < 30; i++) rx_src.push_back({4'($urandom_range(1, 15)), 32'($urandom)});
    n = 0;
    while (!(rx_idx >= 5 && !o_rdn) && (n < 60)) begin step(); n++; end
    chk("t6_in_rx_burst", 64'(o_rdn), 64'(0));
    @(negedge clk);
    rstn = 1'b0;
    #1;
    chk("t6_rdn", 64'(rdn), 64'(1));
    chk("t6_oen", 64'(oen), 64'(1));
    chk("t6_wrn", 64'(wrn), 64'(1));
    chk("t6_tvalid", 64'(m_tvalid), 64'(0));
    chk("t6_ft_rstn", 64'(ft_rstn), 64'(0));
    repeat (3) @(negedge clk);
    rstn = 1'b1;
    base = rx_idx; rx_out.delete(); occ = 0;
    rdy_mode = 2;
    drain_rx("t6", 30 - base, 400);
    chk_rx_order("t6", base);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
